// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int SERIAL_ADD_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of serial_add_ctrl; sub_in exists only with SERIAL_ADD_SUB_EN.
// Handshake: start_in is taken when the block is not busy (IDLE or DONE); the
// result is valid on the single cycle done_out is high and held until the next accepted start.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_in;
`endif
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start_in, a_in, b_in, sub_in,
                    input  busy_out, done_out, sum_out, carry_out);
    modport slave  (input  start_in, a_in, b_in, sub_in,
                    output busy_out, done_out, sum_out, carry_out);
`else
    modport master (output start_in, a_in, b_in,
                    input  busy_out, done_out, sum_out, carry_out);
    modport slave  (input  start_in, a_in, b_in,
                    output busy_out, done_out, sum_out, carry_out);
`endif
endinterface

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half adders; the carries never both set, so OR suffices.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_sum(w_s0),  .o_carry(w_c0));
    half_adder u_ha1 (.i_a(w_s0), .i_b(i_cin), .o_sum(o_sum), .o_carry(w_c1));

    assign o_cout = w_c0 | w_c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: WIDTH RUN cycles, LSB first, one shared full-adder cell.
// Define SERIAL_ADD_SUB_EN to add sub_in (A-B via inverted B and carry-in 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    serial_add_ctrl_if.slave  ctrl_if,
    output state_e            dbg_state_out
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_sub;
    logic             w_sum_bit;
    logic             w_carry_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = ctrl_if.sub_in;
`else
    assign w_sub = 1'b0;
`endif

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_sum_bit, r_res[WIDTH-1:1]};

    serial_fa_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum_bit),
        .o_cout (w_carry_next)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (ctrl_if.start_in) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_a     <= ctrl_if.a_in;
                        r_b     <= ctrl_if.b_in ^ {WIDTH{w_sub}};
                        r_carry <= w_sub;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start_in is deliberately not looked at here
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_next;
                    r_res   <= w_res_next;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_sum   <= w_res_next;
                        r_cout  <= w_carry_next;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_if.busy_out  = r_busy;
    assign ctrl_if.done_out  = r_done;
    assign ctrl_if.sum_out   = r_sum;
    assign ctrl_if.carry_out = r_cout;
    assign dbg_state_out     = r_state;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk_in  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start_in  input  1  request an add; sampled only in IDLE or DONE.
REQ-005 Port: a_in  input  WIDTH  operand A; captured in the cycle start is accepted.
REQ-006 Port: b_in  input  WIDTH  operand B; captured in the cycle start is accepted.
REQ-007 Port: busy_out  output  1  high while a bit-serial operation runs.
REQ-008 Port: done_out  output  1  one-cycle pulse when the result is valid.
REQ-009 Port: sum_out  output  WIDTH  result; held stable from done until the next accepted start.
REQ-010 Port: carry_out  output  1  final carry out of MSB; held with sum_out.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 Transitions: IDLE->RUN on start_in=1; RUN->DONE after WIDTH bit cycles; DONE->RUN on start_in=1; DONE->IDLE on start_in=0.
REQ-013 On accept, a_in and b_in SHALL be latched into shift registers and the carry flop SHALL be cleared.
REQ-014 Each RUN cycle SHALL add one bit, LSB first, using A bit, B bit and carry flop; sum bit shifts into the result MSB end; carry flop updates.
REQ-015 The RUN state SHALL last exactly WIDTH cycles, counted by a bit counter of ceil(log2(WIDTH+1)) bits that wraps to 0 on leaving RUN.
REQ-016 done_out SHALL be high for exactly one cycle, the (WIDTH+1)th cycle after the start-accept edge, and only in DONE.
REQ-017 busy_out SHALL equal (state==RUN), registered.
REQ-018 start_in during RUN SHALL be ignored; there is no queueing and the operands are not modified.
REQ-019 sum_out and carry_out SHALL update only on entry to DONE and SHALL hold through IDLE.
REQ-020 Arithmetic is unsigned modulo 2^WIDTH; carry_out = bit WIDTH of a_in+b_in.

Reset
REQ-021 rst_n_in=0 SHALL force state IDLE, bit counter 0, carry flop 0, busy_out 0, done_out 0, sum_out 0, carry_out 0, asynchronously, including mid-RUN.
REQ-022 The first start SHALL be accepted on the first rising edge with rst_n_in=1 and start_in=1.

Configuration
REQ-023 Macro SERIAL_ADD_SUB_EN defined: add an input port sub_in (1 bit, latched with operands); when 1, B is inverted bitwise and the carry flop initialises to 1, giving A-B, with carry_out=1 meaning no borrow.
REQ-024 Macro SERIAL_ADD_SUB_EN undefined: no sub_in port; behaviour is add-only, per REQ-011..REQ-020.

Structure
REQ-025 Package serial_add_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and the constant SERIAL_ADD_WIDTH_DEF=8.
REQ-026 One sub-module serial_fa_cell SHALL implement the 1-bit full adder as two half_adder instances plus an OR of their carries; serial_add_ctrl instantiates it once.

Verification
REQ-027 WIDTH=8, a=0x0F, b=0x01, start 1 cycle -> busy for 8 cycles, done pulse in cycle 9, sum=0x10, carry=0.
REQ-028 a=0xFF, b=0x01 -> sum=0x00, carry=1; a=0xA5, b=0x5A -> sum=0xFF, carry=0.
REQ-029 start pulsed with new operands in RUN cycle 4 -> ignored; result matches the first operands; no extra done.
REQ-030 rst_n_in low in RUN cycle 5 -> all outputs 0 immediately; the next start gives a correct fresh result.
REQ-031 start held high across DONE -> back-to-back operations; each gives one done pulse every 9 cycles and correct sums.
REQ-032 With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, carry=0; a=0x07, b=0x05 -> sum=0x02, carry=1.
